morse_encoder: RTL and testbench

- Transmit side of the Morse path. Takes one packed 10-bit Morse word, in the format the player input modules store in RAM, and plays it out as a timed on/off mark signal.
- The mark signal drives an LED or buzzer, so the opposing player can read the code.
- Sits between the RAM read port and the board output pins.
- One word is played per start request; completion is signalled by a done pulse.

---
 rtl/morse_encoder_pkg.sv | 22 ++
 rtl/morse_unit_timer.sv | 38 +++
 rtl/morse_encoder.sv | 121 ++++++++++++
 tb/tb_morse_encoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/morse_encoder_pkg.sv
// Shared Morse constants and the encoder state type. The field codes match the
// packed words that the player input modules store in RAM.
package morse_encoder_pkg;

   localparam logic [1:0] MORSE_NONE = 2'b00;
   localparam logic [1:0] MORSE_DOT  = 2'b01;
   localparam logic [1:0] MORSE_LINE = 2'b11;

   localparam int CODE_W   = 10;
   localparam int SYM_W    = 2;
   localparam int MAX_SYMS = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_MARK,
      S_SPACE,
      S_END_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Interval timer: a prescaler that produces one tick per time unit, followed by a
// unit down-counter. A load restarts the prescaler so every interval is exact.
module morse_unit_timer #(
   parameter int UNIT_CYCLES = 25000000,
   parameter int UNITS_W     = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic [UNITS_W-1:0] units,
   output logic               expired
);

   localparam int PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   logic [PRE_W-1:0]   pre;
   logic [UNITS_W-1:0] ucnt;
   logic               unit_tick;

   assign unit_tick = (pre == PRE_W'(UNIT_CYCLES - 1));
   // High on the last cycle of the loaded interval.
   assign expired   = unit_tick && (ucnt == UNITS_W'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre  <= '0;
         ucnt <= '0;
      end else if (load) begin
         pre  <= '0;
         ucnt <= units;
      end else begin
         pre <= unit_tick ? '0 : pre + PRE_W'(1);
         if (unit_tick && (ucnt != '0))
            ucnt <= ucnt - UNITS_W'(1);
      end
   end

endmodule

// File: rtl/morse_encoder.sv
// Plays one packed Morse word as a timed on/off mark signal, oldest field first,
// and pulses done when the trailing gap has elapsed.
module morse_encoder
   import morse_encoder_pkg::*;
#(
   parameter int UNIT_CYCLES = 25000000,
   parameter int DOT_UNITS   = 1,
   parameter int LINE_UNITS  = 3,
   parameter int GAP_UNITS   = 1,
   parameter int END_UNITS   = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CODE_W-1:0] code,
   output logic              mark_out,
   output logic              busy,
   output logic              done
);

   localparam int MAX_UNITS = (LINE_UNITS > END_UNITS) ? LINE_UNITS : END_UNITS;
   localparam int UNITS_W   = $clog2(MAX_UNITS + 1);
   localparam int SCNT_W    = $clog2(MAX_SYMS + 1);

   state_t              state;
   state_t              state_next;
   logic [CODE_W-1:0]   sreg;
   logic [SCNT_W-1:0]   scnt;
   logic                played;
   logic [SYM_W-1:0]    field;
   logic                timer_load;
   logic [UNITS_W-1:0]  timer_units;
   logic                expired;

   assign field = sreg[CODE_W-1 -: SYM_W];

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .UNITS_W     (UNITS_W)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (timer_load),
      .units   (timer_units),
      .expired (expired)
   );

   // The timer is loaded on the same edge that enters a timed state.
   always_comb begin
      state_next  = state;
      timer_load  = 1'b0;
      timer_units = UNITS_W'(GAP_UNITS);
      case (state)
         S_IDLE: if (start) state_next = S_SCAN;
         S_SCAN: begin
            if (scnt != '0) begin
               case (field)
                  MORSE_DOT: begin
                     state_next  = S_MARK;
                     timer_load  = 1'b1;
                     timer_units = UNITS_W'(DOT_UNITS);
                  end
                  MORSE_LINE: begin
                     state_next  = S_MARK;
                     timer_load  = 1'b1;
                     timer_units = UNITS_W'(LINE_UNITS);
                  end
                  MORSE_NONE: state_next = S_SCAN;
                  default:    state_next = S_SCAN;
               endcase
            end else if (played) begin
               state_next  = S_END_GAP;
               timer_load  = 1'b1;
               timer_units = UNITS_W'(END_UNITS);
            end else begin
               state_next = S_DONE;
            end
         end
         S_MARK: begin
            if (expired) begin
               state_next  = S_SPACE;
               timer_load  = 1'b1;
               timer_units = UNITS_W'(GAP_UNITS);
            end
         end
         S_SPACE:   if (expired) state_next = S_SCAN;
         S_END_GAP: if (expired) state_next = S_DONE;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so mark_out cannot glitch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         sreg     <= '0;
         scnt     <= '0;
         played   <= 1'b0;
         mark_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         mark_out <= (state_next == S_MARK);
         busy     <= (state_next != S_IDLE);
         done     <= (state_next == S_DONE);
         if ((state == S_IDLE) && start) begin
            sreg   <= code;
            scnt   <= SCNT_W'(MAX_SYMS);
            played <= 1'b0;
         end else if ((state == S_SCAN) && (scnt != '0)) begin
            sreg <= sreg << SYM_W;
            scnt <= scnt - SCNT_W'(1);
            if (state_next == S_MARK)
               played <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4: per-cycle check of
// {mark_out, busy, done} against hand-computed mark windows and done cycles.
module tb_morse_encoder;

   logic       clock;
   logic       reset;
   logic       start;
   logic [9:0] code;
   logic       mark_out;
   logic       busy;
   logic       done;
   logic       clk_en;

   int tests_run    = 0;
   int tests_failed = 0;

   // Expected mark windows (inclusive cycle ranges) and done cycle of a playback.
   int mk_lo[5];
   int mk_hi[5];
   int n_mk;
   int done_cyc;

   morse_encoder #(
      .UNIT_CYCLES (4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .code     (code),
      .mark_out (mark_out),
      .busy     (busy),
      .done     (done)
   );

   // Clock/reset: clk_en lets the bench stop the clock while reset is exercised.
   initial clock = 1'b0;
   always begin
      #5;
      if (clk_en) clock = ~clock;
   end

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got={mark,busy,done}=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] exp_vec(input int k, input int reset_cyc);
      logic m;
      m = 1'b0;
      if (reset_cyc > 0 && k >= reset_cyc) return 3'b000;
      for (int i = 0; i < n_mk; i++)
         if (k >= mk_lo[i] && k <= mk_hi[i]) m = 1'b1;
      return {m, (k >= 1 && k <= done_cyc), (k == done_cyc)};
   endfunction

   task automatic set_exp(input int n, input int l0, input int h0, input int l1, input int h1,
                          input int d);
      n_mk = n;
      mk_lo[0] = l0; mk_hi[0] = h0;
      mk_lo[1] = l1; mk_hi[1] = h1;
      done_cyc = d;
   endtask

   // Driver: start sampled at edge 0, then cycles 1..ncyc checked at each negedge.
   task automatic play(input string name, input logic [9:0] c, input int ncyc,
                       input int inject_cyc, input int reset_cyc);
      @(negedge clock);
      code  = c;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      code  = ~c;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clock);
         if (k == reset_cyc) begin
            reset = 1'b1;
            #1;
         end
         if (reset_cyc > 0 && k == reset_cyc + 2) reset = 1'b0;
         check($sformatf("%s c%0d", name, k), {mark_out, busy, done}, exp_vec(k, reset_cyc));
         start = (k == inject_cyc);
      end
      start = 1'b0;
   endtask

   initial begin
      clk_en = 1'b1;
      reset  = 1'b1;
      start  = 1'b0;
      code   = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_state", {mark_out, busy, done}, 3'b000);
      reset = 1'b0;

      // Scenario 1: reset with the clock stopped mid-MARK, then an idle stretch.
      set_exp(1, 6, 9, 0, -1, 27);
      play("s1_pre", 10'b00_00_00_00_01, 7, 0, 0);
      clk_en = 1'b0;
      #20;
      reset = 1'b1;
      #1;
      check("s1_async_reset", {mark_out, busy, done}, 3'b000);
      #10;
      reset  = 1'b0;
      clk_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         check($sformatf("s1_idle c%0d", k), {mark_out, busy, done}, 3'b000);
      end

      // Scenario 2: single dot.
      set_exp(1, 6, 9, 0, -1, 27);
      play("s2_dot", 10'b00_00_00_00_01, 30, 0, 0);

      // Scenario 3: dot then line.
      set_exp(2, 5, 8, 14, 25, 43);
      play("s3_dot_line", 10'b00_00_00_01_11, 46, 0, 0);

      // Scenario 4: empty word and all-illegal word.
      set_exp(0, 0, -1, 0, -1, 7);
      play("s4_empty", 10'b00_00_00_00_00, 10, 0, 0);
      play("s4_illegal", 10'b10_10_10_10_10, 10, 0, 0);

      // Scenario 5: five lines; start pulsed during the third mark is ignored.
      n_mk = 5;
      mk_lo[0] = 2;  mk_hi[0] = 13;
      mk_lo[1] = 19; mk_hi[1] = 30;
      mk_lo[2] = 36; mk_hi[2] = 47;
      mk_lo[3] = 53; mk_hi[3] = 64;
      mk_lo[4] = 70; mk_hi[4] = 81;
      done_cyc = 99;
      play("s5_lines", 10'b11_11_11_11_11, 104, 40, 0);

      // Scenario 6: reset during the second mark of the dot-line word, then a dot.
      set_exp(2, 5, 8, 14, 25, 43);
      play("s6_abort", 10'b00_00_00_01_11, 30, 0, 18);
      set_exp(1, 6, 9, 0, -1, 27);
      play("s6_dot", 10'b00_00_00_00_01, 30, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
